// File: rtl/n64_ctrl_sniffer.sv
// Passive N64 joybus sniffer: decodes the console command, captures the
// controller response and hands it over with a sticky-flag/ack handshake.
module n64_ctrl_sniffer #(
   parameter int unsigned RESP_BITS  = 32,
   parameter logic [7:0]  CMD_CODE   = 8'h01,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned BIT_THRESH = 8,
   parameter int unsigned IDLE_CNT   = 192,
   parameter int unsigned BIT_TMO    = 40,
   parameter logic [15:0] IGR_COMBO  = 16'h0,
   parameter int unsigned IGR_HOLD   = 4
) (
   input  logic                 CTRL_CLK,
   input  logic                 CTRL_nRST,
   input  logic                 CTRL_i,
   input  logic                 use_igr_i,
   input  logic                 data_ack_i,
   output logic [RESP_BITS-1:0] ctrl_data_o,
   output logic                 new_ctrl_data_o,
   output logic                 overrun_o,
   output logic                 igr_trigger_o,
   output logic [7:0]           frame_err_cnt_o,
   output logic                 busy_o
);

   localparam int unsigned BC_W = $clog2(RESP_BITS + 1);
   localparam int unsigned HC_W = $clog2(IGR_HOLD + 1);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] IDLE_C    = CNT_W'(IDLE_CNT);
   localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(BIT_TMO);
   localparam logic [BC_W-1:0]  CMD_LEN   = BC_W'(8);
   localparam logic [BC_W-1:0]  RESP_LEN  = BC_W'(RESP_BITS);
   localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(IGR_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_RESP
   } state_t;

   logic [1:0]           sync_q, sync_d;
   logic                 hist_q, hist_d;
   logic [CNT_W-1:0]     dur_cnt_q, dur_cnt_d;
   state_t               state_q, state_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [RESP_BITS-1:0] sr_q, sr_d;
   logic [RESP_BITS-1:0] data_q, data_d;
   logic                 new_q, new_d;
   logic                 ovr_q, ovr_d;
   logic                 trig_q, trig_d;
   logic [7:0]           err_q, err_d;
   logic [HC_W-1:0]      hold_q, hold_d;

   logic rise, fall, bit_val, commit, abort;

   assign rise    = sync_q[1] & ~hist_q;
   assign fall    = ~sync_q[1] & hist_q;
   assign bit_val = (dur_cnt_q < THRESH_C);

   always_comb begin
      sync_d    = {sync_q[0], CTRL_i};
      hist_d    = sync_q[1];
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      data_d    = data_q;
      new_d     = new_q;
      ovr_d     = ovr_q;
      trig_d    = 1'b0;
      err_d     = err_q;
      hold_d    = hold_q;
      commit    = 1'b0;
      abort     = 1'b0;

      if (rise || fall)
         dur_cnt_d = '0;
      else if (dur_cnt_q == CNT_MAX)
         dur_cnt_d = dur_cnt_q;
      else
         dur_cnt_d = dur_cnt_q + CNT_W'(1);

      unique case (state_q)
         ST_IDLE: begin
            if (fall && dur_cnt_q >= IDLE_C) begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
               sr_d      = '0;
            end
         end
         ST_CMD: begin
            if (dur_cnt_q >= TMO_C) begin
               abort = 1'b1;
            end else if (rise) begin
               if (bit_cnt_q == CMD_LEN) begin
                  // Stop bit: only our command arms the response capture
                  if (sr_q[7:0] == CMD_CODE) begin
                     state_d   = ST_RESP;
                     bit_cnt_d = '0;
                     sr_d      = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  sr_d      = {sr_q[RESP_BITS-2:0], bit_val};
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
               end
            end
         end
         ST_RESP: begin
            if (dur_cnt_q >= TMO_C) begin
               abort = 1'b1;
            end else if (rise) begin
               if (bit_cnt_q == RESP_LEN) begin
                  commit  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  sr_d      = {bit_val, sr_q[RESP_BITS-1:1]};
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d = ST_IDLE;
         if (err_q != 8'hFF)
            err_d = err_q + 8'd1;
      end

      // A commit outranks a coincident acknowledge
      if (commit) begin
         data_d = sr_q;
         new_d  = 1'b1;
         ovr_d  = data_ack_i ? 1'b0 : (ovr_q | new_q);
      end else if (data_ack_i) begin
         new_d = 1'b0;
         ovr_d = 1'b0;
      end

      if (!use_igr_i) begin
         hold_d = '0;
      end else if (commit) begin
         if (sr_q[15:0] == IGR_COMBO) begin
            if (hold_q == HOLD_LAST) begin
               trig_d = 1'b1;
               hold_d = '0;
            end else begin
               hold_d = hold_q + HC_W'(1);
            end
         end else begin
            hold_d = '0;
         end
      end
   end

   always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
      if (!CTRL_nRST) begin
         sync_q    <= 2'b11;
         hist_q    <= 1'b1;
         dur_cnt_q <= '0;
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         data_q    <= '0;
         new_q     <= 1'b0;
         ovr_q     <= 1'b0;
         trig_q    <= 1'b0;
         err_q     <= '0;
         hold_q    <= '0;
      end else begin
         sync_q    <= sync_d;
         hist_q    <= hist_d;
         dur_cnt_q <= dur_cnt_d;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         new_q     <= new_d;
         ovr_q     <= ovr_d;
         trig_q    <= trig_d;
         err_q     <= err_d;
         hold_q    <= hold_d;
      end
   end

   assign ctrl_data_o     = data_q;
   assign new_ctrl_data_o = new_q;
   assign overrun_o       = ovr_q;
   assign igr_trigger_o   = trig_q;
   assign frame_err_cnt_o = err_q;
   assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_n64_ctrl_sniffer.sv
// Self-checking bench for n64_ctrl_sniffer: drives joybus waveforms and
// compares against a frame-level model of the sniffer.
module tb_n64_ctrl_sniffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ctrl_i;
   logic        use_igr;
   logic        ack;
   logic [31:0] data_o;
   logic        new_o, ovr_o, trig_o, busy_o;
   logic [7:0]  err_o;

   int n_chk  = 0;
   int n_pass = 0;

   // frame-level reference state
   logic [31:0] m_data;
   bit          m_new, m_ovr;
   int          m_err, m_hold;

   always #5 clk = ~clk;

   n64_ctrl_sniffer dut (
      .CTRL_CLK        (clk),
      .CTRL_nRST       (rst_n),
      .CTRL_i          (ctrl_i),
      .use_igr_i       (use_igr),
      .data_ack_i      (ack),
      .ctrl_data_o     (data_o),
      .new_ctrl_data_o (new_o),
      .overrun_o       (ovr_o),
      .igr_trigger_o   (trig_o),
      .frame_err_cnt_o (err_o),
      .busy_o          (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic line_low(input int n);
      ctrl_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic line_high(input int n);
      ctrl_i = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // 4 MHz: '1' = 1us low 3us high, '0' = 3us low 1us high
   task automatic send_bit(input bit b);
      line_low(b ? 4 : 12);
      line_high(b ? 12 : 4);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_data"}, data_o, m_data);
      chk({tag, "_new"}, {31'd0, new_o}, {31'd0, m_new});
      chk({tag, "_ovr"}, {31'd0, ovr_o}, {31'd0, m_ovr});
      chk({tag, "_err"}, {24'd0, err_o}, m_err);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] word,
                             input int nbits, input int abort_at,
                             input bit ack_c);
      bit commit_exp, trig_exp;
      commit_exp = (cmd == 8'h01) && (nbits == 32) && (abort_at < 0);
      trig_exp   = 1'b0;
      line_high(200);
      for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
      line_low(4);
      line_high(12);
      chk("busy_cmd", {31'd0, busy_o}, {31'd0, cmd == 8'h01});
      for (int i = 0; i < nbits; i++) begin
         if (i == abort_at) begin
            line_low(50);
            line_high(4);
            if (m_err < 255) m_err++;
            chk("abort_busy", {31'd0, busy_o}, 32'd0);
            chk_state("abort");
            return;
         end
         send_bit(word[i]);
      end
      line_low(4);
      ctrl_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_data", data_o, m_data);
      chk("pre_new", {31'd0, new_o}, {31'd0, m_new});
      if (ack_c) ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      if (commit_exp) begin
         m_ovr  = ack_c ? 1'b0 : (m_ovr | m_new);
         m_new  = 1'b1;
         m_data = word;
         if (use_igr && word[15:0] == 16'h0) begin
            m_hold++;
            if (m_hold == 4) begin
               trig_exp = 1'b1;
               m_hold   = 0;
            end
         end else begin
            m_hold = 0;
         end
      end else if (ack_c) begin
         m_new = 1'b0;
         m_ovr = 1'b0;
      end
      chk_state("frame");
      chk("trig", {31'd0, trig_o}, {31'd0, trig_exp});
      chk("busy_end", {31'd0, busy_o}, 32'd0);
      @(negedge clk);
      chk("trig_off", {31'd0, trig_o}, 32'd0);
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack   = 1'b0;
      m_new = 1'b0;
      m_ovr = 1'b0;
      chk("ack_new", {31'd0, new_o}, 32'd0);
      chk("ack_ovr", {31'd0, ovr_o}, 32'd0);
   endtask

   task automatic set_igr(input bit en);
      @(negedge clk);
      use_igr = en;
      if (!en) m_hold = 0;
      @(negedge clk);
   endtask

   function automatic logic [31:0] match_word();
      logic [31:0] r;
      r = $urandom;
      return {r[31:16], 16'h0000};
   endfunction

   function automatic logic [31:0] miss_word();
      logic [31:0] r;
      r = $urandom;
      return r | 32'h1;
   endfunction

   initial begin
      logic [7:0]  rc;
      logic [31:0] rw;
      rst_n   = 1'b0;
      ctrl_i  = 1'b1;
      use_igr = 1'b0;
      ack     = 1'b0;
      m_data  = '0;
      m_new   = 1'b0;
      m_ovr   = 1'b0;
      m_err   = 0;
      m_hold  = 0;
      repeat (4) @(negedge clk);
      chk_state("reset");
      chk("reset_trig", {31'd0, trig_o}, 32'd0);
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      rst_n = 1'b1;

      send_frame(8'h01, 32'h12345678, 32, -1, 1'b0);
      send_frame(8'h00, $urandom, 24, -1, 1'b0);
      send_frame(8'h01, $urandom, 32, -1, 1'b0);
      send_frame(8'h01, $urandom, 32, -1, 1'b0);
      do_ack();
      send_frame(8'h01, $urandom, 32, -1, 1'b0);
      send_frame(8'h01, $urandom, 32, -1, 1'b1);

      for (int k = 0; k < 5; k++) begin
         rc = $urandom;
         rw = $urandom;
         if ($urandom_range(0, 2) != 0) rc = 8'h01;
         send_frame(rc, rw, 32, -1, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1) == 1) do_ack();
      end

      set_igr(1'b1);
      for (int k = 0; k < 4; k++)
         send_frame(8'h01, match_word(), 32, -1, 1'b0);
      send_frame(8'h01, match_word(), 32, -1, 1'b0);
      send_frame(8'h01, match_word(), 32, -1, 1'b0);
      send_frame(8'h01, miss_word(), 32, -1, 1'b0);
      send_frame(8'h01, match_word(), 32, -1, 1'b0);
      set_igr(1'b0);
      set_igr(1'b1);
      for (int k = 0; k < 4; k++)
         send_frame(8'h01, match_word(), 32, -1, 1'b0);
      set_igr(1'b0);

      send_frame(8'h01, $urandom, 32, 10, 1'b0);
      for (int k = 0; k < 255; k++) begin
         line_high(200);
         line_low(44);
         if (m_err < 255) m_err++;
      end
      line_high(4);
      chk_state("err_sat");

      line_high(200);
      for (int i = 7; i >= 0; i--) send_bit(rc[0] | 1'b1 ? (i == 0) : 1'b0);
      line_low(4);
      line_high(12);
      for (int i = 0; i < 10; i++) send_bit($urandom_range(0, 1) == 1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      m_data = '0;
      m_new  = 1'b0;
      m_ovr  = 1'b0;
      m_err  = 0;
      m_hold = 0;
      for (int i = 10; i < 32; i++) send_bit($urandom_range(0, 1) == 1);
      line_low(4);
      line_high(20);
      chk_state("midrst");
      chk("midrst_busy", {31'd0, busy_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
